// File: rtl/tomasulo_rs.sv
// Reservation station for one functional-unit class: holds dispatched ops until both
// operands are resolved (at dispatch or via CDB snoop) and issues the oldest ready op.
package tomasulo_pkg;
  typedef logic [3:0]  opcode_t;
  typedef logic [3:0]  tag_t;
  typedef logic [3:0]  robid_t;
  typedef logic [31:0] word_t;
  typedef logic [15:0] imm_t;

  typedef struct packed {
    logic  busy;
    tag_t  tag;
    word_t word;
  } oprand_t;

  typedef struct packed {
    logic       vld;
    tag_t       tag;
    robid_t     robid;
    logic [4:0] wa;
    word_t      wdata;
  } cdb_t;

  typedef struct packed {
    opcode_t       opcode;
    tag_t          tag;
    robid_t        robid;
    oprand_t [1:0] oprand;
    imm_t          imm;
  } dispatch_t;
endpackage

module tomasulo_rs
  import tomasulo_pkg::*;
#(
  parameter int N = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  cdb_t      cdb_r,
  input  logic      dis_vld,
  input  dispatch_t dis,
  output logic      full_r,
  output logic      issue_vld_r,
  input  logic      issue_rdy,
  output opcode_t   issue_opcode_r,
  output tag_t      issue_tag_r,
  output robid_t    issue_robid_r,
  output word_t     issue_a_r,
  output word_t     issue_b_r,
  output imm_t      issue_imm_r
);

  localparam int IW = $clog2(N);
  localparam int OW = $clog2(N + 1);

  // Shift-compacted queue: slot 0 is the oldest entry, valid slots are contiguous.
  dispatch_t     ent     [N];
  logic [N-1:0]  ent_vld;
  logic [OW-1:0] occ;

  dispatch_t     ent_up  [N];
  logic [N-1:0]  vld_up;
  dispatch_t     ent_nxt [N];
  logic [N-1:0]  vld_nxt;
  logic [OW-1:0] occ_nxt;
  logic [OW-1:0] wpos;
  logic [N-1:0]  ready;
  logic [IW-1:0] sel;
  logic          any_ready;
  logic          load;
  logic          write;

  logic unused_cdb;
  assign unused_cdb = ^{cdb_r.robid, cdb_r.wa};

  function automatic oprand_t snoop(input oprand_t o, input cdb_t c);
    oprand_t r;
    r = o;
    if (c.vld && o.busy && (o.tag == c.tag)) begin
      r.busy = 1'b0;
      r.word = c.wdata;
    end
    return r;
  endfunction

  function automatic dispatch_t snoop_ent(input dispatch_t e, input cdb_t c);
    dispatch_t r;
    r           = e;
    r.oprand[0] = snoop(e.oprand[0], c);
    r.oprand[1] = snoop(e.oprand[1], c);
    return r;
  endfunction

  // Select: readiness comes from registered state only, lowest slot wins.
  always_comb begin
    sel       = '0;
    any_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      ready[i] = ent_vld[i] & ~ent[i].oprand[0].busy & ~ent[i].oprand[1].busy;
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (ready[i]) begin
        sel       = IW'(i);
        any_ready = 1'b1;
      end
    end
  end

  assign load    = any_ready & (~issue_vld_r | issue_rdy);
  assign write   = dis_vld & (occ != OW'(N));
  assign wpos    = occ - {{(OW-1){1'b0}}, load};
  assign occ_nxt = occ + {{(OW-1){1'b0}}, write} - {{(OW-1){1'b0}}, load};

  always_comb begin
    for (int i = 0; i < N - 1; i++) begin
      ent_up[i] = ent[i + 1];
    end
    ent_up[N-1] = ent[N-1];
    vld_up      = {1'b0, ent_vld[N-1:1]};
  end

  // Next queue: close the gap left by the issued slot, snoop, then append the dispatch.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      if (load && (i >= int'(sel))) begin
        vld_nxt[i] = vld_up[i];
        ent_nxt[i] = snoop_ent(ent_up[i], cdb_r);
      end else begin
        vld_nxt[i] = ent_vld[i];
        ent_nxt[i] = snoop_ent(ent[i], cdb_r);
      end
      if (write && (i == int'(wpos))) begin
        vld_nxt[i] = 1'b1;
        ent_nxt[i] = snoop_ent(dis, cdb_r);
      end
    end
  end

  // Control state
  always_ff @(posedge clk) begin
    if (rst) begin
      ent_vld     <= '0;
      occ         <= '0;
      full_r      <= 1'b0;
      issue_vld_r <= 1'b0;
    end else begin
      ent_vld <= vld_nxt;
      occ     <= occ_nxt;
      // Leaves room for the one dispatch already in flight from the dispatcher.
      full_r  <= (occ_nxt >= OW'(N - 1));
      if (load) begin
        issue_vld_r <= 1'b1;
      end else if (issue_rdy) begin
        issue_vld_r <= 1'b0;
      end
    end
  end

  // Payload state
  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      ent[i] <= ent_nxt[i];
    end
    if (load) begin
      issue_opcode_r <= ent[sel].opcode;
      issue_tag_r    <= ent[sel].tag;
      issue_robid_r  <= ent[sel].robid;
      issue_a_r      <= ent[sel].oprand[0].word;
      issue_b_r      <= ent[sel].oprand[1].word;
      issue_imm_r    <= ent[sel].imm;
    end
  end

  overflow_chk: assert property (@(posedge clk) disable iff (rst)
    !(dis_vld && (occ == OW'(N))));

endmodule
